sha2_msg_sched: RTL and testbench
=================================

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the message word width; legal values 32 (SHA-256) and 64 (SHA-512); other values are a elaboration error.
REQ-002 SHALL have localparam ROUNDS, which is 64 when WORD_W=32 and 80 when WORD_W=64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port srst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port blk_valid  input  1  a message block is offered on blk_data.
REQ-006 SHALL have port blk_ready  output  1  the block can accept a message block.
REQ-007 SHALL have port blk_data  input  16*WORD_W  block; word 0 in the MSBs, word 15 in the LSBs.
REQ-008 SHALL have port abort  input  1  synchronous abandon of the block in progress.
REQ-009 SHALL have port w_valid  output  1  w carries a schedule word.
REQ-010 SHALL have port w_ready  input  1  downstream consumer accepts w.
REQ-011 SHALL have port w  output  WORD_W  schedule word W[t].
REQ-012 SHALL have port w_rnd  output  7  index t of the word on w.
REQ-013 SHALL have port w_last  output  1  the word on w is W[ROUNDS-1].

Function
REQ-014 SHALL hold a 16-word window win[0..15] of WORD_W bits each, a 7-bit round counter and a two-state FSM with states IDLE and RUN.
REQ-015 SHALL drive blk_ready=1 exactly when the FSM is in IDLE; a block is accepted on a cycle where blk_valid&blk_ready=1.
REQ-016 On block acceptance, SHALL load win[i]=blk_data word i, clear the round counter to 0 and move to RUN; w_valid=1 with w=W[0] on the next cycle (latency 1).
REQ-017 In RUN, SHALL drive w=win[0], w_rnd=round counter and w_valid=1; w_last=1 only when w_rnd=ROUNDS-1.
REQ-018 On a w transfer (w_valid&w_ready), SHALL shift win[i]<=win[i+1] for i=0..14, set win[15]<=sigma1(win[14])+win[9]+sigma0(win[1])+win[0] modulo 2^WORD_W, and increment the round counter.
REQ-019 With WORD_W=32, SHALL use sigma0=ROTR7^ROTR18^SHR3 and sigma1=ROTR17^ROTR19^SHR10.
REQ-020 With WORD_W=64, SHALL use sigma0=ROTR1^ROTR8^SHR7 and sigma1=ROTR19^ROTR61^SHR6.
REQ-021 With w_ready=0, SHALL hold w, w_rnd, w_last, the window and the counter stable, with w_valid staying 1 (no drop, no skip).
REQ-022 On a transfer with w_rnd=ROUNDS-1, SHALL go to IDLE, deassert w_valid and assert blk_ready on the next cycle; the counter does not wrap inside a block.
REQ-023 In IDLE, SHALL hold w_valid=0 and w_last=0; w and w_rnd keep their last values and are don't-care.
REQ-024 When abort=1, SHALL on the next edge enter IDLE, clear the window and counter to 0 and deassert w_valid, regardless of state.
REQ-025 abort SHALL have priority over a simultaneous w transfer and over block acceptance (no block is accepted on an abort cycle).
REQ-026 SHALL ignore blk_valid while in RUN; blk_data is sampled only on the acceptance cycle.

Reset
REQ-027 While srst_n=0, SHALL immediately, without a clock edge, set FSM=IDLE, window=0, counter=0, w_valid=0, w_last=0, w_rnd=0, w=0 and blk_ready=1.
REQ-028 A reset asserted mid-block SHALL discard the block; after release, the first accepted block starts at t=0.

Verification
REQ-029 Test: WORD_W=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; w_last=1 only at w_rnd=63; blk_ready=1 one cycle after the 64th transfer.
REQ-030 Test: same block, w_ready toggled pseudo-randomly -> identical 64-word sequence; w, w_rnd and w_valid are stable through every stall cycle.
REQ-031 Test: WORD_W=64, "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000; exactly 80 words; w_last at w_rnd=79.
REQ-032 Test: abort pulsed at w_rnd=20 with a simultaneous transfer -> w_valid=0 next cycle and blk_ready=1; the next block starts at w_rnd=0 with correct words.
REQ-033 Test: srst_n asserted asynchronously between edges at w_rnd=35 -> w_valid falls immediately; a fresh block after release produces the golden sequence.
REQ-034 Test: blk_valid held high during RUN with changing blk_data -> no effect on the output sequence; the second block is accepted only in IDLE.

Source files
------------

// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule: expands a 16-word block into W[0..ROUNDS-1], one word per w transfer.
// Latency 1 from block acceptance to W[0]; a stalled w holds the word, index and window in place.
module sha2_msg_sched #(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
  input  logic                 abort,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w,
  output logic [6:0]           w_rnd,
  output logic                 w_last
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] win [16];
  logic [6:0]        cnt;
  logic [WORD_W-1:0] w_new;
  logic              accept, xfer;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  assign accept = blk_valid && blk_ready;
  assign xfer   = w_valid && w_ready;
  assign w_new  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign w      = win[0];
  assign w_rnd  = cnt;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = RUN;
      end
      RUN: begin
        w_valid = 1'b1;
        w_last  = (cnt == 7'(ROUNDS - 1));
        if (w_ready && w_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // abort wins over both acceptance and the final transfer
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (abort) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (accept) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) win[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
    end else if (xfer) begin
      cnt <= cnt + 7'd1;
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Randomised bench for sha2_msg_sched at both word widths, against a FIPS-style array schedule model.
module tb_sha2_msg_sched;

  logic clk = 1'b0;
  logic srst_n;
  always #5 clk = ~clk;

  logic         blk_valid32, blk_ready32, abort32, w_valid32, w_ready32, w_last32;
  logic [511:0] blk_data32;
  logic [31:0]  w32;
  logic [6:0]   w_rnd32;

  logic          blk_valid64, blk_ready64, abort64, w_valid64, w_ready64, w_last64;
  logic [1023:0] blk_data64;
  logic [63:0]   w64;
  logic [6:0]    w_rnd64;

  sha2_msg_sched #(.WORD_W(32)) u_dut32 (
    .clk(clk), .srst_n(srst_n), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
    .blk_data(blk_data32), .abort(abort32), .w_valid(w_valid32), .w_ready(w_ready32),
    .w(w32), .w_rnd(w_rnd32), .w_last(w_last32));

  sha2_msg_sched #(.WORD_W(64)) u_dut64 (
    .clk(clk), .srst_n(srst_n), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
    .blk_data(blk_data64), .abort(abort64), .w_valid(w_valid64), .w_ready(w_ready64),
    .w(w64), .w_rnd(w_rnd64), .w_last(w_last64));

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mw  [80];
  logic [63:0] obs [80];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int wd);
    logic [127:0] d;
    if (wd == 32) begin
      d = {64'b0, x[31:0], x[31:0]} >> n;
      return {32'b0, d[31:0]};
    end
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [63:0] ss0(input logic [63:0] x, input int wd);
    if (wd == 32) return rot(x, 7, wd) ^ rot(x, 18, wd) ^ (x >> 3);
    return rot(x, 1, wd) ^ rot(x, 8, wd) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ss1(input logic [63:0] x, input int wd);
    if (wd == 32) return rot(x, 17, wd) ^ rot(x, 19, wd) ^ (x >> 10);
    return rot(x, 19, wd) ^ rot(x, 61, wd) ^ (x >> 6);
  endfunction

  // Textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  function automatic void build_model(input logic [1023:0] b, input int wd);
    int r;
    r = (wd == 32) ? 64 : 80;
    for (int t = 0; t < 16; t++)
      mw[t] = (wd == 32) ? {32'b0, b[(15-t)*32 +: 32]} : b[(15-t)*64 +: 64];
    for (int t = 16; t < r; t++) begin
      mw[t] = ss1(mw[t-2], wd) + mw[t-7] + ss0(mw[t-15], wd) + mw[t-16];
      if (wd == 32) mw[t][63:32] = 32'b0;
    end
  endfunction

  task automatic samp(input int wd, output logic [63:0] v, output logic vl,
                      output logic [6:0] rn, output logic la, output logic br);
    if (wd == 32) begin
      v = {32'b0, w32}; vl = w_valid32; rn = w_rnd32; la = w_last32; br = blk_ready32;
    end else begin
      v = w64; vl = w_valid64; rn = w_rnd64; la = w_last64; br = blk_ready64;
    end
  endtask

  task automatic set_ready(input int wd, input logic r);
    if (wd == 32) w_ready32 = r;
    else          w_ready64 = r;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic offer(input int wd, input logic [1023:0] b);
    logic [63:0] v; logic vl, la, br; logic [6:0] rn;
    int k;
    k = 0;
    samp(wd, v, vl, rn, la, br);
    while (!br && k < 200) begin
      @(posedge clk); #1;
      samp(wd, v, vl, rn, la, br);
      k++;
    end
    chk("blk_ready_wait", {63'b0, br}, 64'd1);
    if (wd == 32) begin blk_valid32 = 1'b1; blk_data32 = b[511:0]; end
    else          begin blk_valid64 = 1'b1; blk_data64 = b; end
    @(posedge clk); #1;
    if (wd == 32) blk_valid32 = 1'b0;
    else          blk_valid64 = 1'b0;
  endtask

  task automatic drain(input int wd, input logic [1023:0] b, input bit stall,
                       input int abort_at, input int rst_at, input bit hammer,
                       input logic [511:0] nxt);
    logic [63:0] v, pv; logic vl, la, br, pvl, pla; logic [6:0] rn, prn;
    logic rdy, pstall;
    int r, idx, cyc;
    r = (wd == 32) ? 64 : 80;
    build_model(b, wd);
    idx = 0; cyc = 0; pstall = 1'b0;
    pv = '0; pvl = 1'b0; pla = 1'b0; prn = '0;
    while (idx < r && cyc < 2000) begin
      samp(wd, v, vl, rn, la, br);
      if (pstall) begin
        chk($sformatf("stall_w[%0d]", idx), v, pv);
        chk($sformatf("stall_rnd[%0d]", idx), {57'b0, rn}, {57'b0, prn});
        chk($sformatf("stall_vld[%0d]", idx), {63'b0, vl}, {63'b0, pvl});
        chk($sformatf("stall_last[%0d]", idx), {63'b0, la}, {63'b0, pla});
      end
      chk($sformatf("vld[%0d]", idx), {63'b0, vl}, 64'd1);
      chk($sformatf("w[%0d]", idx), v, mw[idx]);
      chk($sformatf("rnd[%0d]", idx), {57'b0, rn}, 64'(idx));
      chk($sformatf("last[%0d]", idx), {63'b0, la}, {63'b0, (idx == r - 1)});
      obs[idx] = v;
      if (hammer) begin
        blk_valid32 = 1'b1;
        blk_data32  = rand512();
      end
      if (idx == rst_at) begin
        set_ready(wd, 1'b0);
        #3 srst_n = 1'b0;
        #1;
        samp(wd, v, vl, rn, la, br);
        chk("rst_vld", {63'b0, vl}, 64'd0);
        chk("rst_rdy", {63'b0, br}, 64'd1);
        chk("rst_rnd", {57'b0, rn}, 64'd0);
        chk("rst_w", v, 64'd0);
        @(posedge clk); #1;
        srst_n = 1'b1;
        return;
      end
      if (idx == abort_at) begin
        abort32 = 1'b1;
        set_ready(wd, 1'b1);
        @(posedge clk); #1;
        abort32 = 1'b0;
        set_ready(wd, 1'b0);
        samp(wd, v, vl, rn, la, br);
        chk("abort_vld", {63'b0, vl}, 64'd0);
        chk("abort_rdy", {63'b0, br}, 64'd1);
        chk("abort_rnd", {57'b0, rn}, 64'd0);
        chk("abort_w", v, 64'd0);
        return;
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(wd, rdy);
      if (rdy) idx++;
      pstall = !rdy; pv = v; pvl = vl; pla = la; prn = rn;
      @(posedge clk); #1;
      cyc++;
    end
    set_ready(wd, 1'b0);
    chk("word_count", 64'(idx), 64'(r));
    samp(wd, v, vl, rn, la, br);
    chk("end_vld", {63'b0, vl}, 64'd0);
    chk("end_last", {63'b0, la}, 64'd0);
    chk("end_rdy", {63'b0, br}, 64'd1);
    if (hammer) begin
      blk_data32 = nxt;
      @(posedge clk); #1;
      blk_valid32 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v; logic vl, la, br; logic [6:0] rn;
    logic [511:0]  abc32, rb, rb2;
    logic [1023:0] abc64, rb64;
    abc32 = {32'h61626380, 448'h0, 32'h00000018};
    abc64 = {64'h6162638000000000, 896'h0, 64'h18};
    blk_valid32 = 0; blk_data32 = '0; abort32 = 0; w_ready32 = 0;
    blk_valid64 = 0; blk_data64 = '0; abort64 = 0; w_ready64 = 0;
    srst_n = 1'b0;
    #12;
    for (int wd = 32; wd <= 64; wd += 32) begin
      samp(wd, v, vl, rn, la, br);
      chk("reset_rdy", {63'b0, br}, 64'd1);
      chk("reset_vld", {63'b0, vl}, 64'd0);
      chk("reset_last", {63'b0, la}, 64'd0);
      chk("reset_rnd", {57'b0, rn}, 64'd0);
      chk("reset_w", v, 64'd0);
    end
    @(posedge clk); #1;
    srst_n = 1'b1;
    @(posedge clk); #1;

    offer(32, abc32);
    drain(32, abc32, 0, -1, -1, 0, '0);
    chk("abc_W16", obs[16], 64'h61626380);
    chk("abc_W17", obs[17], 64'h000F0000);
    chk("abc_W18", obs[18], 64'h7DA86405);

    offer(32, abc32);
    drain(32, abc32, 1, -1, -1, 0, '0);

    offer(64, abc64);
    drain(64, abc64, 0, -1, -1, 0, '0);
    chk("abc64_W16", obs[16], 64'h6162638000000000);

    rb = rand512();
    offer(32, rb);
    drain(32, rb, 0, 20, -1, 0, '0);
    offer(32, abc32);
    drain(32, abc32, 0, -1, -1, 0, '0);

    rb = rand512();
    offer(32, rb);
    drain(32, rb, 1, -1, 35, 0, '0);
    offer(32, abc32);
    drain(32, abc32, 0, -1, -1, 0, '0);
    chk("post_rst_W18", obs[18], 64'h7DA86405);

    rb = rand512(); rb2 = rand512();
    offer(32, rb);
    drain(32, rb, 1, -1, -1, 1, rb2);
    drain(32, rb2, 1, -1, -1, 0, '0);

    for (int n = 0; n < 3; n++) begin
      rb64 = {rand512(), rand512()};
      offer(64, rb64);
      drain(64, rb64, 1, -1, -1, 0, '0);
      rb = rand512();
      offer(32, rb);
      drain(32, rb, 1, -1, -1, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
